// File: rtl/shifter_load_gen.sv
`default_nettype none
// ============================================================================
// Module   : shifter_load_gen
// Brief    : Video word fetcher with 4-deep FIFO and 2-clock LOAD strobe
//            generator for the shifter word interface (STe scroll/skip aware).
// Revision : 1.0 - initial release
// ============================================================================
module shifter_load_gen (
    input  logic        clk32,
    input  logic        nReset,
    input  logic        busClkEn,
    input  logic        DE,
    input  logic        VBL,
    input  logic [1:0]  rez,
    input  logic        scroll,
    input  logic [21:0] vid_base,
    input  logic [7:0]  line_wid,
    output logic        mem_req,
    output logic [21:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic        LOAD,
    output logic [15:0] DOUT,
    output logic        underrun
);

    localparam logic [2:0] C_EXTRA_LOW  = 3'd4;
    localparam logic [2:0] C_EXTRA_MID  = 3'd2;
    localparam logic [2:0] C_EXTRA_HIGH = 3'd1;
    localparam logic [2:0] C_FIFO_DEPTH = 3'd4;

    logic [1:0]  ph_q, ph_d;
    logic        vbl_q, vbl_d;
    logic        de_q, de_d;
    logic        fetch_act_q, fetch_act_d;
    logic        load_act_q, load_act_d;
    logic [2:0]  extra_q, extra_d;
    logic [21:0] ptr_q, ptr_d;
    logic        req_q, req_d;
    logic [21:0] addr_q, addr_d;
    logic        discard_q, discard_d;
    logic [15:0] fifo_q [4];
    logic [15:0] fifo_d [4];
    logic [1:0]  wr_q, wr_d;
    logic [1:0]  rd_q, rd_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        load_q, load_d;
    logic        load2_q, load2_d;
    logic [15:0] dout_q, dout_d;
    logic        underrun_q, underrun_d;

    logic        w_slot;
    logic        w_vbl_rise;
    logic        w_ack;
    logic        w_push;
    logic        w_pop;
    logic        w_line_end;
    logic [2:0]  w_extra;

    assign w_slot     = busClkEn && (ph_q == 2'd3);
    assign w_vbl_rise = VBL && !vbl_q;
    assign w_ack      = req_q && mem_ack;
    // Data for a request that straddled a VBL restart belongs to the old frame.
    assign w_push     = w_ack && !discard_q && !w_vbl_rise;
    assign w_pop      = w_slot && load_act_q && (cnt_q != 3'd0) && !w_vbl_rise;
    assign w_extra    = rez[1] ? C_EXTRA_HIGH : (rez[0] ? C_EXTRA_MID : C_EXTRA_LOW);

    always_comb begin
        ph_d        = busClkEn ? ph_q + 2'd1 : ph_q;
        vbl_d       = VBL;
        de_d        = de_q;
        fetch_act_d = fetch_act_q;
        load_act_d  = load_act_q;
        extra_d     = extra_q;
        req_d       = req_q;
        addr_d      = addr_q;
        discard_d   = discard_q;
        fifo_d      = fifo_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        load_d      = load_q;
        load2_d     = load2_q;
        dout_d      = dout_q;
        underrun_d  = underrun_q;
        w_line_end  = 1'b0;

        if (w_slot) begin
            de_d       = DE;
            load_act_d = fetch_act_q;
            if (DE) begin
                fetch_act_d = 1'b1;
                extra_d     = 3'd0;
            end else if (fetch_act_q) begin
                if (de_q && scroll) begin
                    extra_d = w_extra - 3'd1;
                end else if (!de_q && (extra_q != 3'd0)) begin
                    extra_d = extra_q - 3'd1;
                end else begin
                    fetch_act_d = 1'b0;
                    w_line_end  = 1'b1;
                end
            end
            if (fetch_act_q && (cnt_q < C_FIFO_DEPTH) && !req_q) begin
                req_d  = 1'b1;
                addr_d = ptr_q;
            end
            if (load_act_q && (cnt_q == 3'd0)) begin
                underrun_d = 1'b1;
            end
        end

        if (w_ack) begin
            req_d     = 1'b0;
            discard_d = 1'b0;
        end

        ptr_d = ptr_q + {21'd0, w_push} + (w_line_end ? {14'd0, line_wid} : 22'd0);

        if (w_push) begin
            fifo_d[wr_q] = mem_data;
            wr_d         = wr_q + 2'd1;
        end

        if (w_pop) begin
            dout_d  = fifo_q[rd_q];
            rd_d    = rd_q + 2'd1;
            load_d  = 1'b1;
            load2_d = 1'b0;
        end else if (load_q && !load2_q) begin
            load2_d = 1'b1;
        end else if (load_q) begin
            load_d  = 1'b0;
            load2_d = 1'b0;
        end

        cnt_d = cnt_q + {2'd0, w_push} - {2'd0, w_pop};

        if (w_vbl_rise) begin
            ptr_d       = vid_base;
            wr_d        = 2'd0;
            rd_d        = 2'd0;
            cnt_d       = 3'd0;
            fetch_act_d = 1'b0;
            load_act_d  = 1'b0;
            extra_d     = 3'd0;
            underrun_d  = 1'b0;
            req_d       = w_ack ? 1'b0 : req_q;
            addr_d      = addr_q;
            discard_d   = req_q && !mem_ack;
        end
    end

    always_ff @(posedge clk32 or negedge nReset) begin
        if (!nReset) begin
            ph_q        <= 2'd0;
            vbl_q       <= 1'b0;
            de_q        <= 1'b0;
            fetch_act_q <= 1'b0;
            load_act_q  <= 1'b0;
            extra_q     <= 3'd0;
            ptr_q       <= 22'd0;
            req_q       <= 1'b0;
            addr_q      <= 22'd0;
            discard_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 16'd0;
            end
            wr_q        <= 2'd0;
            rd_q        <= 2'd0;
            cnt_q       <= 3'd0;
            load_q      <= 1'b0;
            load2_q     <= 1'b0;
            dout_q      <= 16'd0;
            underrun_q  <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            vbl_q       <= vbl_d;
            de_q        <= de_d;
            fetch_act_q <= fetch_act_d;
            load_act_q  <= load_act_d;
            extra_q     <= extra_d;
            ptr_q       <= ptr_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            discard_q   <= discard_d;
            fifo_q      <= fifo_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            load_q      <= load_d;
            load2_q     <= load2_d;
            dout_q      <= dout_d;
            underrun_q  <= underrun_d;
        end
    end

    assign mem_req  = req_q;
    assign mem_addr = addr_q;
    assign LOAD     = load_q;
    assign DOUT     = dout_q;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_shifter_load_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_shifter_load_gen
// Brief    : Self-checking bench for shifter_load_gen with a memory responder
//            and an address/data reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shifter_load_gen;

    logic        clk32;
    logic        nReset;
    logic        busClkEn;
    logic        DE;
    logic        VBL;
    logic [1:0]  rez;
    logic        scroll;
    logic [21:0] vid_base;
    logic [7:0]  line_wid;
    logic        mem_req;
    logic [21:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        LOAD;
    logic [15:0] DOUT;
    logic        underrun;

    int checks;
    int failures;
    int cyc;
    int req_n;
    int slow_idx;
    int ack_delay;
    int width_bad;
    int dout_bad;

    logic [21:0] req_addr_q [$];
    int          req_cyc_q  [$];
    logic [15:0] ack_data_q [$];
    logic [15:0] load_dout_q[$];
    int          load_cyc_q [$];
    logic [21:0] exp_addr_q [$];

    shifter_load_gen u_dut (
        .clk32    (clk32),
        .nReset   (nReset),
        .busClkEn (busClkEn),
        .DE       (DE),
        .VBL      (VBL),
        .rez      (rez),
        .scroll   (scroll),
        .vid_base (vid_base),
        .line_wid (line_wid),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .LOAD     (LOAD),
        .DOUT     (DOUT),
        .underrun (underrun)
    );

    initial begin
        clk32 = 1'b0;
        forever #5 clk32 = ~clk32;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk32);
            cyc = cyc + 1;
        end
    end

    initial begin
        logic [1:0] bcnt;
        bcnt     = 2'd0;
        busClkEn = 1'b0;
        forever begin
            @(negedge clk32);
            bcnt     = bcnt + 2'd1;
            busClkEn = (bcnt == 2'd0);
        end
    end

    // Memory responder: acks each request after ack_delay clocks (20 for the slow one).
    initial begin
        int d;
        mem_ack  = 1'b0;
        mem_data = 16'd0;
        forever begin
            @(negedge clk32);
            if (nReset === 1'b1 && mem_req === 1'b1) begin
                req_n = req_n + 1;
                req_addr_q.push_back(mem_addr);
                req_cyc_q.push_back(cyc);
                d = (req_n == slow_idx) ? 20 : ack_delay;
                repeat (d - 1) @(negedge clk32);
                mem_ack  = 1'b1;
                mem_data = 16'($urandom);
                ack_data_q.push_back(mem_data);
                @(negedge clk32);
                mem_ack  = 1'b0;
            end
        end
    end

    initial begin
        int          run;
        int          hold;
        logic [15:0] cap;
        run  = 0;
        hold = 0;
        cap  = 16'd0;
        forever begin
            @(negedge clk32);
            if (nReset !== 1'b1) begin
                run  = 0;
                hold = 0;
            end else begin
                if (hold > 0) begin
                    if (DOUT !== cap) dout_bad = dout_bad + 1;
                    hold = hold - 1;
                end
                if (LOAD === 1'b1) begin
                    if (run == 0) begin
                        cap  = DOUT;
                        hold = 3;
                        load_dout_q.push_back(DOUT);
                        load_cyc_q.push_back(cyc);
                    end
                    run = run + 1;
                end else begin
                    if (run != 0 && run != 2) width_bad = width_bad + 1;
                    run = 0;
                end
            end
        end
    end

    function automatic int extra_words(input logic scr, input logic [1:0] rz);
        if (!scr)        return 0;
        else if (rz[1])  return 1;
        else if (rz[0])  return 2;
        else             return 4;
    endfunction

    task automatic model_addrs(input logic [21:0] base, input int lw, input int nlines, input int words);
        logic [21:0] p;
        exp_addr_q.delete();
        p = base;
        for (int l = 0; l < nlines; l++) begin
            for (int i = 0; i < words; i++) exp_addr_q.push_back(p + 22'(i));
            p = p + 22'(words + lw);
        end
    endtask

    task automatic clear_logs();
        req_addr_q.delete();
        req_cyc_q.delete();
        ack_data_q.delete();
        load_dout_q.delete();
        load_cyc_q.delete();
        req_n     = 0;
        width_bad = 0;
        dout_bad  = 0;
    endtask

    task automatic pulse_vbl();
        @(negedge clk32);
        VBL = 1'b1;
        repeat (2) @(negedge clk32);
        VBL = 1'b0;
        repeat (4) @(negedge clk32);
    endtask

    task automatic do_lines(input logic [21:0] base, input logic [7:0] lw, input int nlines,
                            input int nslots, input logic scr, input logic [1:0] rz);
        vid_base = base;
        line_wid = lw;
        scroll   = scr;
        rez      = rz;
        pulse_vbl();
        clear_logs();
        for (int l = 0; l < nlines; l++) begin
            DE = 1'b1;
            repeat (nslots * 16) @(negedge clk32);
            DE = 1'b0;
            repeat (12 * 16) @(negedge clk32);
        end
    endtask

    task automatic test_reset();
        int bad_req, bad_load, bad_dout, bad_und;
        bad_req = 0; bad_load = 0; bad_dout = 0; bad_und = 0;
        nReset = 1'b0; DE = 1'b0; VBL = 1'b0; rez = 2'd0; scroll = 1'b0;
        vid_base = 22'd0; line_wid = 8'd0;
        repeat (5) @(negedge clk32);
        nReset = 1'b1;
        repeat (100) begin
            @(negedge clk32);
            if (mem_req !== 1'b0)   bad_req++;
            if (LOAD !== 1'b0)      bad_load++;
            if (DOUT !== 16'd0)     bad_dout++;
            if (underrun !== 1'b0)  bad_und++;
        end
        checks++; if (bad_req != 0)  begin failures++; $display("FAIL reset_mem_req bad_cycles=%0d required=0", bad_req); end
        checks++; if (bad_load != 0) begin failures++; $display("FAIL reset_load bad_cycles=%0d required=0", bad_load); end
        checks++; if (bad_dout != 0) begin failures++; $display("FAIL reset_dout bad_cycles=%0d required=0", bad_dout); end
        checks++; if (bad_und != 0)  begin failures++; $display("FAIL reset_underrun bad_cycles=%0d required=0", bad_und); end
        checks++; if (mem_addr !== 22'd0) begin failures++; $display("FAIL reset_mem_addr got=%h required=0", mem_addr); end
    endtask

    task automatic test_fetch_load();
        int bad, n;
        do_lines(22'h010000, 8'd0, 1, 20, 1'b0, 2'd0);
        model_addrs(22'h010000, 0, 1, 20);
        checks++; if (req_addr_q.size() != 20) begin failures++; $display("FAIL basic_req_count got=%0d required=20", req_addr_q.size()); end
        n = (req_addr_q.size() < 20) ? req_addr_q.size() : 20;
        bad = 0; for (int i = 0; i < n; i++) if (req_addr_q[i] !== exp_addr_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL basic_addr mismatches=%0d required=0", bad); end
        checks++; if (load_dout_q.size() != 20) begin failures++; $display("FAIL basic_load_count got=%0d required=20", load_dout_q.size()); end
        n = (load_dout_q.size() < ack_data_q.size()) ? load_dout_q.size() : ack_data_q.size();
        bad = 0; for (int i = 0; i < n; i++) if (load_dout_q[i] !== ack_data_q[i]) bad++;
        checks++; if (bad != 0 || n != 20) begin failures++; $display("FAIL basic_dout_seq mismatches=%0d compared=%0d required=0/20", bad, n); end
        bad = 0; for (int i = 1; i < load_cyc_q.size(); i++) if (load_cyc_q[i] - load_cyc_q[i-1] != 16) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL basic_load_spacing bad=%0d required=0", bad); end
        if (load_cyc_q.size() > 0 && req_cyc_q.size() > 0) begin
            checks++;
            if (load_cyc_q[0] - req_cyc_q[0] != 16) begin
                failures++; $display("FAIL basic_first_latency got=%0d required=16", load_cyc_q[0] - req_cyc_q[0]);
            end
        end
        checks++; if (width_bad != 0) begin failures++; $display("FAIL basic_load_width bad=%0d required=0", width_bad); end
        checks++; if (dout_bad != 0)  begin failures++; $display("FAIL basic_dout_stable bad=%0d required=0", dout_bad); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL basic_underrun got=%b required=0", underrun); end
    endtask

    task automatic test_scroll();
        logic [1:0] rz;
        int w, bad, n;
        for (int k = 0; k < 3; k++) begin
            rz = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
            w  = 20 + extra_words(1'b1, rz);
            do_lines(22'h012340, 8'd0, 1, 20, 1'b1, rz);
            model_addrs(22'h012340, 0, 1, w);
            checks++; if (req_addr_q.size() != w) begin failures++; $display("FAIL scroll_req_count rez=%0d got=%0d required=%0d", rz, req_addr_q.size(), w); end
            checks++; if (load_dout_q.size() != w) begin failures++; $display("FAIL scroll_load_count rez=%0d got=%0d required=%0d", rz, load_dout_q.size(), w); end
            n = (req_addr_q.size() < w) ? req_addr_q.size() : w;
            bad = 0; for (int i = 0; i < n; i++) if (req_addr_q[i] !== exp_addr_q[i]) bad++;
            n = (load_dout_q.size() < ack_data_q.size()) ? load_dout_q.size() : ack_data_q.size();
            for (int i = 0; i < n; i++) if (load_dout_q[i] !== ack_data_q[i]) bad++;
            checks++; if (bad != 0) begin failures++; $display("FAIL scroll_addr_data rez=%0d mismatches=%0d required=0", rz, bad); end
        end
        scroll = 1'b0;
    endtask

    task automatic test_line_wid();
        int bad, n;
        do_lines(22'h020000, 8'd8, 2, 4, 1'b0, 2'd0);
        model_addrs(22'h020000, 8, 2, 4);
        checks++; if (req_addr_q.size() != 8) begin failures++; $display("FAIL lwid_req_count got=%0d required=8", req_addr_q.size()); end
        n = (req_addr_q.size() < 8) ? req_addr_q.size() : 8;
        bad = 0; for (int i = 0; i < n; i++) if (req_addr_q[i] !== exp_addr_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL lwid_addr mismatches=%0d required=0", bad); end
        if (req_addr_q.size() > 4) begin
            checks++;
            if (req_addr_q[4] !== 22'h02000C) begin failures++; $display("FAIL lwid_line2_start got=%h required=02000c", req_addr_q[4]); end
        end
        checks++; if (load_dout_q.size() != 8) begin failures++; $display("FAIL lwid_load_count got=%0d required=8", load_dout_q.size()); end
    endtask

    task automatic test_underrun();
        int bad, n, gaps32;
        slow_idx = 5;
        do_lines(22'h030000, 8'd0, 1, 20, 1'b0, 2'd0);
        slow_idx = 0;
        model_addrs(22'h030000, 0, 1, 19);
        checks++; if (req_addr_q.size() != 19) begin failures++; $display("FAIL udr_req_count got=%0d required=19", req_addr_q.size()); end
        checks++; if (load_dout_q.size() != 19) begin failures++; $display("FAIL udr_load_count got=%0d required=19", load_dout_q.size()); end
        n = (req_addr_q.size() < 19) ? req_addr_q.size() : 19;
        bad = 0; for (int i = 0; i < n; i++) if (req_addr_q[i] !== exp_addr_q[i]) bad++;
        n = (load_dout_q.size() < ack_data_q.size()) ? load_dout_q.size() : ack_data_q.size();
        for (int i = 0; i < n; i++) if (load_dout_q[i] !== ack_data_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL udr_addr_data mismatches=%0d required=0", bad); end
        bad = 0; gaps32 = 0;
        for (int i = 1; i < load_cyc_q.size(); i++) begin
            if (load_cyc_q[i] - load_cyc_q[i-1] == 32) gaps32++;
            else if (load_cyc_q[i] - load_cyc_q[i-1] != 16) bad++;
        end
        checks++; if (gaps32 != 1 || bad != 0) begin failures++; $display("FAIL udr_missing_load gaps32=%0d other=%0d required=1/0", gaps32, bad); end
        repeat (200) @(negedge clk32);
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL udr_sticky got=%b required=1", underrun); end
        pulse_vbl();
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL udr_vbl_clear got=%b required=0", underrun); end
    endtask

    task automatic test_vbl_discard();
        int t, bad, n;
        ack_delay = 10;
        vid_base  = 22'h040000;
        pulse_vbl();
        clear_logs();
        DE = 1'b1;
        t  = 0;
        while (mem_req !== 1'b1 && t < 200) begin
            @(negedge clk32);
            t++;
        end
        checks++; if (t >= 200) begin failures++; $display("FAIL vbl_req_timeout waited=%0d required<200", t); end
        repeat (2) @(negedge clk32);
        vid_base = 22'h035000;
        VBL = 1'b1;
        DE  = 1'b0;
        repeat (2) @(negedge clk32);
        VBL = 1'b0;
        repeat (12 * 16) @(negedge clk32);
        checks++; if (load_dout_q.size() != 0) begin failures++; $display("FAIL vbl_discard_loads got=%0d required=0", load_dout_q.size()); end
        ack_delay = 2;
        clear_logs();
        DE = 1'b1;
        repeat (2 * 16) @(negedge clk32);
        DE = 1'b0;
        repeat (12 * 16) @(negedge clk32);
        checks++; if (req_addr_q.size() != 2) begin failures++; $display("FAIL vbl_req_count got=%0d required=2", req_addr_q.size()); end
        if (req_addr_q.size() > 0) begin
            checks++;
            if (req_addr_q[0] !== 22'h035000) begin failures++; $display("FAIL vbl_new_base got=%h required=035000", req_addr_q[0]); end
        end
        n = (load_dout_q.size() < ack_data_q.size()) ? load_dout_q.size() : ack_data_q.size();
        bad = 0; for (int i = 0; i < n; i++) if (load_dout_q[i] !== ack_data_q[i]) bad++;
        checks++; if (bad != 0 || load_dout_q.size() != 2) begin failures++; $display("FAIL vbl_new_data mismatches=%0d loads=%0d required=0/2", bad, load_dout_q.size()); end
    endtask

    task automatic test_wrap();
        do_lines(22'h3FFFFF, 8'd0, 1, 2, 1'b0, 2'd0);
        checks++; if (req_addr_q.size() != 2) begin failures++; $display("FAIL wrap_req_count got=%0d required=2", req_addr_q.size()); end
        if (req_addr_q.size() > 1) begin
            checks++;
            if (req_addr_q[1] !== 22'h000000) begin failures++; $display("FAIL wrap_addr got=%h required=000000", req_addr_q[1]); end
        end
        checks++; if (load_dout_q.size() != 2) begin failures++; $display("FAIL wrap_load_count got=%0d required=2", load_dout_q.size()); end
    endtask

    task automatic test_async_reset();
        do_lines(22'h050000, 8'd0, 0, 0, 1'b0, 2'd0);
        DE = 1'b1;
        repeat (5 * 16 + 3) @(negedge clk32);
        #2 nReset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || LOAD !== 1'b0 || DOUT !== 16'd0 || underrun !== 1'b0 || mem_addr !== 22'd0) begin
            failures++;
            $display("FAIL async_reset req=%b load=%b dout=%h und=%b addr=%h required=all zero", mem_req, LOAD, DOUT, underrun, mem_addr);
        end
        DE = 1'b0;
        repeat (30) @(negedge clk32);
        nReset = 1'b1;
        repeat (5) @(negedge clk32);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        req_n     = 0;
        slow_idx  = 0;
        ack_delay = 2;
        width_bad = 0;
        dout_bad  = 0;
        test_reset();
        test_fetch_load();
        test_scroll();
        test_line_wid();
        test_underrun();
        test_vbl_discard();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
